// File: rtl/imem_fetch_unit.sv
// Byte-loaded instruction memory with a single-cycle big-endian word fetch port.
// Optional per-byte even parity is built when IMEM_PARITY_EN is defined.
module imem_fetch_unit #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              instr_valid,
    output logic [31:0]       instr_code,
    output logic              misalign_err,
    output logic              range_err,
    output logic              parity_err
);

    localparam int PW = $clog2(DEPTH_BYTES);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [7:0]    mem [DEPTH_BYTES];

    logic          wr_en;
    logic          go;
    logic          mis;
    logic          rng;
    logic [PW-1:0] base;
    logic [31:0]   rd_word;

    assign wr_en = reset && (state == LOAD) && load_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= LOAD;
            ptr        <= '0;
            load_ready <= 1'b1;
            load_done  <= 1'b0;
        end else if (state == LOAD && load_valid) begin
            ptr <= ptr + 1'b1;
            if (load_last || ptr == PW'(DEPTH_BYTES - 1)) begin
                state      <= RUN;
                load_ready <= 1'b0;
                load_done  <= 1'b1;
            end
        end
    end

    // Memory has no reset so a reload simply overwrites the previous image.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= load_byte;
        end
    end

    assign go      = (state == RUN) && fetch_req;
    assign mis     = |fetch_addr[1:0];
    assign rng     = fetch_addr > ADDR_W'(DEPTH_BYTES - 4);
    assign base    = {fetch_addr[PW-1:2], 2'b00};
    assign rd_word = {mem[base], mem[base | PW'(1)],
                      mem[base | PW'(2)], mem[base | PW'(3)]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_valid  <= 1'b0;
            instr_code   <= '0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
        end else if (!fetch_stall) begin
            instr_valid  <= go;
            misalign_err <= go && mis;
            range_err    <= go && rng;
            instr_code   <= (go && !mis && !rng) ? rd_word : 32'h0;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par [DEPTH_BYTES];
    logic par_bad;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par[ptr] <= ^load_byte;
        end
    end

    assign par_bad = (par[base]          ^ (^mem[base]))
                   | (par[base | PW'(1)] ^ (^mem[base | PW'(1)]))
                   | (par[base | PW'(2)] ^ (^mem[base | PW'(2)]))
                   | (par[base | PW'(3)] ^ (^mem[base | PW'(3)]));

    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (!fetch_stall) begin
            parity_err <= go && !mis && !rng && par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a byte-array model predicts every cycle,
// a negedge monitor compares; a second 8-byte instance covers the full-depth load.
module tb_imem_fetch_unit;

    localparam int DEPTH = 256;

    typedef struct packed {
        logic        v;
        logic [31:0] code;
        logic        mis;
        logic        rng;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lv = 1'b0;
    logic [7:0]  lb = '0;
    logic        ll = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        stall = 1'b0;
    logic        load_ready, load_done, instr_valid;
    logic [31:0] instr_code;
    logic        misalign_err, range_err, parity_err;

    logic        r8 = 1'b0;
    logic        lv8 = 1'b0;
    logic [7:0]  lb8 = '0;
    logic        ll8 = 1'b0;
    logic        req8 = 1'b0;
    logic [31:0] a8 = '0;
    logic        stall8 = 1'b0;
    logic        ready8, done8, valid8;
    logic [31:0] code8;
    logic        mis8, rng8, par8;

    int total = 0;
    int bad = 0;

    exp_t       sbq[$];
    logic [7:0] mmem [DEPTH];
    int         mptr = 0;
    bit         mloaded = 0;
    exp_t       cur = '0;

    always #5 clk = ~clk;

    imem_fetch_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .reset(rst),
        .load_valid(lv), .load_byte(lb), .load_last(ll),
        .load_ready(load_ready), .load_done(load_done),
        .fetch_req(req), .fetch_addr(addr), .fetch_stall(stall),
        .instr_valid(instr_valid), .instr_code(instr_code),
        .misalign_err(misalign_err), .range_err(range_err),
        .parity_err(parity_err)
    );

    imem_fetch_unit #(.DEPTH_BYTES(8), .ADDR_W(32)) dut8 (
        .clk(clk), .reset(r8),
        .load_valid(lv8), .load_byte(lb8), .load_last(ll8),
        .load_ready(ready8), .load_done(done8),
        .fetch_req(req8), .fetch_addr(a8), .fetch_stall(stall8),
        .instr_valid(valid8), .instr_code(code8),
        .misalign_err(mis8), .range_err(rng8),
        .parity_err(par8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Next-cycle prediction from the current inputs, then advance one clock.
    task automatic step();
        exp_t n;
        if (!rst) begin
            mptr    = 0;
            mloaded = 0;
            cur     = '0;
        end else begin
            n = cur;
            if (!stall) begin
                n = '0;
                if (mloaded && req) begin
                    n.v   = 1'b1;
                    n.mis = (addr % 4) != 0;
                    n.rng = addr > 32'(DEPTH - 4);
                    if (!n.mis && !n.rng)
                        n.code = {mmem[addr], mmem[addr + 1],
                                  mmem[addr + 2], mmem[addr + 3]};
                end
            end
            if (!mloaded && lv) begin
                mmem[mptr] = lb;
                mptr++;
                if (ll || mptr == DEPTH) mloaded = 1;
            end
            cur = n;
        end
        cur.done = mloaded;
        @(posedge clk);
        sbq.push_back(cur);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("instr_valid", 32'(instr_valid), 32'(e.v));
            chk("instr_code", instr_code, e.code);
            chk("misalign_err", 32'(misalign_err), 32'(e.mis));
            chk("range_err", 32'(range_err), 32'(e.rng));
            chk("parity_err", 32'(parity_err), 32'h0);
            chk("load_done", 32'(load_done), 32'(e.done));
            chk("load_ready", 32'(load_ready), 32'(!e.done));
        end
    end

    task automatic load1(input logic [7:0] b, input logic last);
        lv = 1'b1;
        lb = b;
        ll = last;
        step();
        lv = 1'b0;
        ll = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        req  = 1'b1;
        addr = a;
        step();
        req  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] img [8];
        logic [7:0] b8 [8];

        // Reset, partial load, fetch attempt during load, then reload.
        step();
        step();
        rst = 1'b1;
        req = 1'b1;
        addr = 0;
        load1(8'h11, 0);
        load1(8'h22, 0);
        load1(8'h33, 0);
        chk("fetch_in_load", 32'(instr_valid), 32'h0);
        req = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        load1(8'hAC, 0);
        load1(8'h02, 0);
        load1(8'h00, 0);
        load1(8'h0C, 1);
        chk("reload_done", 32'(load_done), 32'h1);
        fetch(0);
        chk("reload_word", instr_code, 32'hAC02000C);

        // Reference program image.
        rst = 1'b0;
        step();
        rst = 1'b1;
        img = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h00, 8'h02, 8'h18, 8'h20};
        for (int i = 0; i < 8; i++) load1(img[i], i == 7);
        fetch(0);
        chk("word0", instr_code, 32'h00011020);
        fetch(4);
        chk("word4", instr_code, 32'h00021820);
        fetch(0);
        stall = 1'b1;
        req = 1'b1;
        addr = 4;
        repeat (3) begin
            step();
            chk("stall_hold", instr_code, 32'h00011020);
        end
        stall = 1'b0;
        step();
        chk("after_stall", instr_code, 32'h00021820);
        req = 1'b0;
        step();
        fetch(6);
        chk("misalign_flag", 32'(misalign_err), 32'h1);
        fetch(32'h100);
        chk("range_flag", 32'(range_err), 32'h1);
        fetch(32'hFD);
        fetch(32'hFC);
        fetch(32'hFFFF_FFFC);
        step();

        // Full-depth random image with gaps, ending without load_last.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(0, 3) == 0) step();
            load1(8'($urandom), 0);
        end
        chk("full_done", 32'(load_done), 32'h1);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) addr = 32'($urandom_range(0, 63) * 4);
            else if (r < 8) addr = 32'($urandom_range(0, 300));
            else addr = $urandom;
            req   = $urandom_range(0, 3) != 0;
            stall = $urandom_range(0, 3) == 0;
            lv    = $urandom_range(0, 1);
            lb    = 8'($urandom);
            ll    = $urandom_range(0, 1);
            step();
        end
        req = 1'b0;
        stall = 1'b0;
        lv = 1'b0;
        ll = 1'b0;
        step();

        // Eight-byte instance: fills to the last byte without load_last.
        r8 = 1'b0;
        step();
        r8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b8[i] = 8'($urandom);
            lv8 = 1'b1;
            lb8 = b8[i];
            chk("d8_ready_load", 32'(ready8), 32'h1);
            step();
        end
        chk("d8_done", 32'(done8), 32'h1);
        lb8 = ~b8[0];
        step();
        chk("d8_ready_run", 32'(ready8), 32'h0);
        lv8 = 1'b0;
        req8 = 1'b1;
        a8 = 0;
        step();
        chk("d8_word0", code8, {b8[0], b8[1], b8[2], b8[3]});
        a8 = 4;
        step();
        chk("d8_word4", code8, {b8[4], b8[5], b8[6], b8[7]});
        a8 = 8;
        step();
        chk("d8_range", 32'(rng8), 32'h1);
        chk("d8_range_code", code8, 32'h0);
        chk("d8_valid", 32'(valid8), 32'h1);
        req8 = 1'b0;
        step();
        chk("d8_idle", 32'(valid8), 32'h0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
